// File: rtl/tia_frame_capture_pkg.sv
// Shared constants and types for the Atari video path.
// The frame-capture stage and the VGA scan-out stage both use these, so the
// frame-buffer geometry is defined in one place.
package tia_frame_capture_pkg;

  localparam int unsigned FB_WIDTH  = 160;  // visible pixels per stored line
  localparam int unsigned FB_HEIGHT = 240;  // maximum stored lines per frame
  localparam int unsigned FB_ADDR_W = 16;   // frame-buffer address width
  localparam int unsigned COLOR_W   = 7;    // TIA colour index width

  // Capture state: wait for a first vsync, sit in sync, then capture lines.
  typedef enum logic [1:0] {
    StWaitVs,
    StSync,
    StActive
  } cap_state_e;

endpackage

// File: rtl/tia_frame_capture_sync_edge_detect.sv
// Registers a sync level once and flags its rising and falling edges.
// The edge pulses compare the live input against the registered copy, so
// they are combinational and line up with the sample that caused them.
//
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   level_i - sync level input
//   rise_o  - level_i is 1 now and was 0 on the previous cycle
//   fall_o  - level_i is 0 now and was 1 on the previous cycle
module tia_frame_capture_sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic rise_o,
  output logic fall_o
);

  logic level_q;
  logic level_d;

  assign level_d = level_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign rise_o = level_i & ~level_q;
  assign fall_o = ~level_i & level_q;

endmodule

// File: rtl/tia_frame_capture.sv
// Captures the TIA pixel stream into the shared frame buffer.
// Each accepted pixel produces one write at y*WIDTH + x, one cycle after it is
// sampled. Frame boundaries come from vsync; lines advance on hsync only when
// the line actually stored something, so blank lines do not consume rows.
//
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   pix_valid, pix_color      - one strobe per TIA colour clock, colour index
//   tia_hsync/vsync/vblank    - TIA sync and blank levels
//   wr_en, wr_addr, wr_data   - frame-buffer write port
//   frame_done                - one-cycle pulse at the end of each frame
//   frame_lines               - lines captured in the last completed frame
//   overflow                  - sticky per frame: a pixel or line did not fit
module tia_frame_capture
  import tia_frame_capture_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned HEIGHT = FB_HEIGHT,
  parameter int unsigned ADDR_W = FB_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               tia_hsync,
  input  logic               tia_vsync,
  input  logic               tia_vblank,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               frame_done,
  output logic [7:0]         frame_lines,
  output logic               overflow
);

  localparam int unsigned XW = $clog2(WIDTH + 1);
  localparam int unsigned YW = $clog2(HEIGHT + 1);
  localparam int unsigned SW = YW + 1;

  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic unused_hs_fall;

  tia_frame_capture_sync_edge_detect u_hs_edge (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .level_i(tia_hsync),
    .rise_o (hs_rise),
    .fall_o (hs_fall)
  );

  tia_frame_capture_sync_edge_detect u_vs_edge (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .level_i(tia_vsync),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  assign unused_hs_fall = hs_fall;

  cap_state_e         state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]  base_q, base_d;  // always y_q * WIDTH
  logic               line_used_q, line_used_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0] wr_data_q, wr_data_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         frame_lines_q, frame_lines_d;
  logic               overflow_q, overflow_d;
  logic [SW-1:0]      lines_sum;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    base_d        = base_q;
    line_used_d   = line_used_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    frame_lines_d = frame_lines_q;
    overflow_d    = overflow_q;
    lines_sum     = {1'b0, y_q} + SW'(line_used_q);

    unique case (state_q)
      StWaitVs: begin
        if (vs_rise) state_d = StSync;
      end
      StSync: begin
        if (vs_fall) begin
          state_d     = StActive;
          x_d         = '0;
          y_d         = '0;
          base_d      = '0;
          line_used_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      StActive: begin
        if (vs_rise) begin
          // A pixel arriving with the vsync rise is dropped.
          state_d      = StSync;
          frame_done_d = 1'b1;
          frame_lines_d = (lines_sum > SW'(HEIGHT)) ? 8'(HEIGHT) : 8'(lines_sum);
        end else begin
          if (pix_valid && !tia_vblank) begin
            if ((x_q < XW'(WIDTH)) && (y_q < YW'(HEIGHT))) begin
              wr_en_d     = 1'b1;
              wr_addr_d   = base_q + ADDR_W'(x_q);
              wr_data_d   = pix_color;
              x_d         = x_q + XW'(1);
              line_used_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
          // Uses line_used_d so a pixel on the hsync-rise cycle counts for the
          // line it closes.
          if (hs_rise) begin
            x_d = '0;
            if (line_used_d) begin
              if (y_q < YW'(HEIGHT)) begin
                y_d    = y_q + YW'(1);
                base_d = base_q + ADDR_W'(WIDTH);
              end
              line_used_d = 1'b0;
            end
          end
        end
      end
      default: state_d = StWaitVs;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StWaitVs;
      x_q           <= '0;
      y_q           <= '0;
      base_q        <= '0;
      line_used_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_lines_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      base_q        <= base_d;
      line_used_q   <= line_used_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      frame_lines_q <= frame_lines_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = frame_done_q;
  assign frame_lines = frame_lines_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/tia_frame_capture.md
Name: tia_frame_capture

Overview:
Upstream neighbour of the VGA scan-out stage. Takes the TIA's native pixel stream (7-bit colour index per colour clock, plus HSYNC/VSYNC/VBLANK levels) and writes it into the shared 160x240 frame buffer at address y*WIDTH + x. The scan-out stage later reads that buffer through its own read port. Also tracks frame boundaries, which lets downstream logic detect NTSC/PAL line counts.

Parameters:
WIDTH, 160, visible pixels per TIA line; pixels past this are dropped
HEIGHT, 240, maximum lines stored per frame; lines past this are dropped
ADDR_W, 16, frame-buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_valid  in  1  one-cycle strobe, one per TIA colour clock
pix_color  in  7  colour index; sampled when pix_valid=1
tia_hsync  in  1  TIA horizontal sync level
tia_vsync  in  1  TIA vertical sync level
tia_vblank  in  1  TIA vertical blank level; 1 = line not visible
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_W  frame-buffer write address
wr_data  out  7  frame-buffer write data
frame_done  out  1  one-cycle pulse at the end of each frame
frame_lines  out  8  lines captured in the last completed frame
overflow  out  1  sticky; set when pixels or lines exceed WIDTH/HEIGHT; cleared at each new frame

Behaviour:
- Reset (async assert, sync-free release): state=WAIT_VS; x=0; y=0; wr_en=0; wr_addr=0; wr_data=0; frame_done=0; frame_lines=0; overflow=0; all edge-detect registers=0.
- Edge detection: tia_hsync and tia_vsync are registered once. The rise is the current value AND NOT the previous value.
- FSM:
  - WAIT_VS: ignore pixels. On vsync rise -> SYNC.
  - SYNC: ignore pixels. On vsync fall -> ACTIVE; x=0, y=0, line_used=0, overflow=0, base=0.
  - ACTIVE: capture (rules below). On vsync rise -> SYNC; pulse frame_done; frame_lines = y + line_used, saturating at HEIGHT.
- Capture in ACTIVE, when pix_valid=1, tia_vblank=0 and there is no vsync rise this cycle:
  - if x<WIDTH and y<HEIGHT: next cycle wr_en=1, wr_addr=base+x, wr_data=pix_color; x++; line_used=1.
  - otherwise: no write; overflow=1.
- Latency: exactly 1 cycle from the pix_valid sample to wr_en. wr_en lasts 1 cycle per accepted pixel.
- Address arithmetic: incremental, no multiplier. base is a register holding y*WIDTH. wr_addr = base + x, truncated to ADDR_W.
- Line advance: on hsync rise in ACTIVE, if line_used=1: y++ (saturate at HEIGHT), base += WIDTH, line_used=0. x is reset to 0 on every hsync rise.
  - Blank lines (vblank=1, or no pixels) do not advance y.
  - Short lines are not padded; untouched locations keep stale data.
- Simultaneous events:
  - pix_valid with hsync rise: the pixel belongs to the old line; the advance happens after it.
  - pix_valid with vsync rise: the pixel is dropped.
- A vsync rise while already in SYNC has no effect. A frame that never sees a vsync fall is never captured.
- Async reset mid-line: wr_en drops immediately. The partial frame is abandoned, and capture restarts at the next full vsync.

Decomposition:
- Shared package (e.g. atari_video_pkg): FB_WIDTH=160, FB_HEIGHT=240, FB_ADDR_W=16, COLOR_W=7, and the capture-state enum {WAIT_VS, SYNC, ACTIVE}. The VGA scan-out stage uses the same constants.
- One natural sub-module: sync_edge_detect (register plus rise/fall pulse), instantiated for hsync and vsync.

Test Plan:
- Reset, then vsync pulse, then 1 line of 160 pixels with colours 0..127,0..31 -> 160 writes, addresses 0..159, data matching; then hsync; frame_lines=1 after the next vsync rise.
- 3 visible lines plus 37 vblank lines, each with 160 pixels -> only the visible lines are written, at addresses 0..479. Address 160 carries line 1 pixel 0. frame_done pulses once; frame_lines=3.
- Line of 170 pixels -> writes at x=0..159 only; overflow=1; the next frame's vsync fall clears overflow.
- 250 visible lines -> the last write is at address 38399; frame_lines=240; overflow=1.
- pix_valid together with hsync rise at x=5 -> pixel written at base+5, the next line starts at base+160. pix_valid together with vsync rise -> no write; frame_done=1 the next cycle.
- rst_n low mid-line at x=80 -> wr_en=0 immediately; pixels before the next vsync fall produce no writes; after that the capture starts at address 0.
